mprjram_arbiter: RTL and testbench

//   Shares the single-port user-project BRAM (mprjram, 0x3800_0000) between the

---
 rtl/mprjram_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_mprjram_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mprjram_arbiter.sv
// mprjram_arbiter: shares the single-port user-project BRAM between the
// management-core Wishbone slave and the local accelerator master. One access
// is sequenced at a time (IDLE -> ISSUE -> WAIT -> RESP). The fixed BRAM read
// latency is counted, and the response is returned to whichever side owns
// the access.
// Optional macro MPRJRAM_ARB_WB_PRIO_EN: when defined, Wishbone always wins a
// simultaneous request. Otherwise (the default) the two sides alternate
// round-robin.
module mprjram_arbiter #(
  parameter int         ADDR_W = 10,
  parameter int         RD_LAT = 10,
  parameter logic [7:0] BASE   = 8'h38
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic              acc_req,
  input  logic              acc_we,
  input  logic [ADDR_W-1:0] acc_addr,
  input  logic [31:0]       acc_wdata,
  output logic              acc_gnt,
  output logic              acc_rvalid,
  output logic [31:0]       acc_rdata,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state, state_d;
  logic              owner_acc, owner_acc_d;
  logic              is_write, is_write_d;
  logic              aborted, aborted_d;
  logic [3:0]        cnt, cnt_d;
`ifndef MPRJRAM_ARB_WB_PRIO_EN
  logic              last_acc, last_acc_d;
`endif

  logic              ack_d, gnt_d, rvalid_d, en_d;
  logic [3:0]        we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [31:0]       wdata_d, dat_d, rdata_d;

  logic              wb_req;
  logic [ADDR_W-1:0] wb_word;
  logic              pick_acc;
  logic              wb_live;
  logic              unused_adr;

  assign wb_req     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:24] == BASE);
  assign wb_word    = wbs_adr_i[ADDR_W+1:2];
  // Address bits between the BRAM window and the mprjram select do not take
  // part in decoding.
  assign unused_adr = &{1'b0, wbs_adr_i[23:ADDR_W+2], wbs_adr_i[1:0]};

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d     = state;
    owner_acc_d = owner_acc;
    is_write_d  = is_write;
    aborted_d   = aborted;
    cnt_d       = cnt;
`ifndef MPRJRAM_ARB_WB_PRIO_EN
    last_acc_d  = last_acc;
`endif
    pick_acc    = 1'b0;
    ack_d       = 1'b0;
    gnt_d       = 1'b0;
    rvalid_d    = 1'b0;
    en_d        = 1'b0;
    we_d        = 4'h0;
    addr_d      = ram_addr;
    wdata_d     = ram_wdata;
    dat_d       = wbs_dat_o;
    rdata_d     = acc_rdata;
    // The Wishbone owner still wants its ack only if the cycle was never dropped.
    wb_live     = ~owner_acc & ~aborted & wbs_cyc_i;

    case (state)
      IDLE: begin
`ifdef MPRJRAM_ARB_WB_PRIO_EN
        pick_acc = acc_req & ~wb_req;
`else
        pick_acc = acc_req & (~wb_req | ~last_acc);
`endif
        if (wb_req | acc_req) begin
          state_d     = ISSUE;
          owner_acc_d = pick_acc;
          aborted_d   = 1'b0;
          en_d        = 1'b1;
          gnt_d       = pick_acc;
`ifndef MPRJRAM_ARB_WB_PRIO_EN
          last_acc_d  = pick_acc;
`endif
          if (pick_acc) begin
            is_write_d = acc_we;
            we_d       = acc_we ? 4'hF : 4'h0;
            addr_d     = acc_addr;
            wdata_d    = acc_wdata;
          end else begin
            is_write_d = wbs_we_i;
            we_d       = wbs_we_i ? wbs_sel_i : 4'h0;
            addr_d     = wb_word;
            wdata_d    = wbs_dat_i;
          end
        end
      end
      ISSUE: begin
        aborted_d = aborted | (~owner_acc & ~wbs_cyc_i);
        if (is_write) begin
          state_d = RESP;
          ack_d   = wb_live;
        end else begin
          state_d = WAIT;
          cnt_d   = 4'(RD_LAT - 1);
        end
      end
      WAIT: begin
        aborted_d = aborted | (~owner_acc & ~wbs_cyc_i);
        if (cnt == 4'd0) begin
          state_d = RESP;
          if (owner_acc) begin
            rvalid_d = 1'b1;
            rdata_d  = ram_rdata;
          end else if (wb_live) begin
            ack_d = 1'b1;
            dat_d = ram_rdata;
          end
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, bookkeeping and output registers; reset abandons any access in flight.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      owner_acc  <= 1'b0;
      is_write   <= 1'b0;
      aborted    <= 1'b0;
      cnt        <= 4'd0;
`ifndef MPRJRAM_ARB_WB_PRIO_EN
      last_acc   <= 1'b1;
`endif
      wbs_ack_o  <= 1'b0;
      wbs_dat_o  <= 32'h0;
      acc_gnt    <= 1'b0;
      acc_rvalid <= 1'b0;
      acc_rdata  <= 32'h0;
      ram_en     <= 1'b0;
      ram_we     <= 4'h0;
      ram_addr   <= '0;
      ram_wdata  <= 32'h0;
    end else begin
      state      <= state_d;
      owner_acc  <= owner_acc_d;
      is_write   <= is_write_d;
      aborted    <= aborted_d;
      cnt        <= cnt_d;
`ifndef MPRJRAM_ARB_WB_PRIO_EN
      last_acc   <= last_acc_d;
`endif
      wbs_ack_o  <= ack_d;
      wbs_dat_o  <= dat_d;
      acc_gnt    <= gnt_d;
      acc_rvalid <= rvalid_d;
      acc_rdata  <= rdata_d;
      ram_en     <= en_d;
      ram_we     <= we_d;
      ram_addr   <= addr_d;
      ram_wdata  <= wdata_d;
    end
  end

endmodule

// File: tb/tb_mprjram_arbiter.sv
// tb_mprjram_arbiter: directed stimulus for mprjram_arbiter. Expected output
// pulses are queued when stimulus is issued, and a negedge monitor pops and
// compares them. A behavioural BRAM with RL-cycle read latency is attached.
module tb_mprjram_arbiter;
  localparam int RL = 10;
  localparam int AW = 10;
  localparam int K_EN = 0, K_GNT = 1, K_ACK = 2, K_RV = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]    sel = 4'h0;
  logic [31:0]   adr = 32'h0, dat_i = 32'h0;
  logic          ack;
  logic [31:0]   dat_o;
  logic          acc_req = 1'b0, acc_we = 1'b0;
  logic [AW-1:0] acc_addr = '0;
  logic [31:0]   acc_wdata = 32'h0;
  logic          acc_gnt, acc_rvalid;
  logic [31:0]   acc_rdata;
  logic          ram_en;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata, ram_rdata;

  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] data;
    bit          chk;
  } evt_t;

  evt_t exp_q[$];
  int   cyc_n = 0;
  int   checks = 0;
  int   errors = 0;
  int   en_seen = 0;
  int   ack_seen = 0;

  mprjram_arbiter #(.ADDR_W(AW), .RD_LAT(RL), .BASE(8'h38)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .acc_req(acc_req), .acc_we(acc_we), .acc_addr(acc_addr), .acc_wdata(acc_wdata),
    .acc_gnt(acc_gnt), .acc_rvalid(acc_rvalid), .acc_rdata(acc_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Behavioural BRAM: word i starts as A5A5_0000+i; reads appear RL cycles after ram_en.
  logic [31:0] mem [1024];
  logic [31:0] pipe [RL];
  logic        init_done = 1'b0;
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'hA5A5_0000 | 32'(i);
      init_done <= 1'b1;
    end else if (ram_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
    pipe[0] <= ram_en ? mem[ram_addr] : 32'h0;
    for (int k = 1; k < RL; k++) pipe[k] <= pipe[k-1];
  end
  assign ram_rdata = pipe[RL-1];

  task automatic push(input int k, input int cy, input logic [31:0] a,
                      input logic [3:0] w, input logic [31:0] d, input bit ck);
    evt_t e;
    e.kind = k; e.cyc = cy; e.addr = a; e.we = w; e.data = d; e.chk = ck;
    exp_q.push_back(e);
  endtask

  task automatic check_evt(input int k, input string nm);
    evt_t        e;
    logic [31:0] act_d;
    bit          ok;
    checks++;
    if (k == K_EN)       act_d = ram_wdata;
    else if (k == K_ACK) act_d = dat_o;
    else if (k == K_RV)  act_d = acc_rdata;
    else                 act_d = 32'h0;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected pulse at cycle %0d (data %h), required no pulse", nm, cyc_n, act_d);
      return;
    end
    e  = exp_q.pop_front();
    ok = (e.kind == k) && (e.cyc == cyc_n);
    if (k == K_EN) ok = ok && (ram_addr == e.addr[AW-1:0]) && (ram_we == e.we) && (ram_wdata == e.data);
    if ((k == K_ACK && e.chk) || k == K_RV) ok = ok && (act_d == e.data);
    if (!ok) begin
      errors++;
      $display("FAIL %s: got kind %0d cycle %0d addr %0h we %h data %h; required kind %0d cycle %0d addr %0h we %h data %h",
               nm, k, cyc_n, ram_addr, ram_we, act_d, e.kind, e.cyc, e.addr, e.we, e.data);
    end
  endtask

  // Monitor: every output pulse must match the next queued expectation.
  initial forever begin
    @(negedge clk);
    if (ram_en)     begin en_seen++;  check_evt(K_EN, "ram_en");      end
    if (acc_gnt)    check_evt(K_GNT, "acc_gnt");
    if (ack)        begin ack_seen++; check_evt(K_ACK, "wbs_ack_o"); end
    if (acc_rvalid) check_evt(K_RV, "acc_rvalid");
  end

  function automatic bit outs_zero();
    return !(ack | acc_gnt | acc_rvalid | ram_en) && ram_we == 4'h0 && ram_addr == '0 &&
           ram_wdata == 32'h0 && dat_o == 32'h0 && acc_rdata == 32'h0;
  endfunction

  // Single Wishbone access held until its ack, with expectations queued up front.
  task automatic wb_txn(input logic [31:0] a, input bit w, input logic [3:0] s,
                        input logic [31:0] d, input int word, input logic [31:0] exp_rd);
    int c, hold;
    @(posedge clk); #1;
    c = cyc_n;
    cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; dat_i = d;
    push(K_EN, c + 1, 32'(word), w ? s : 4'h0, d, 1'b0);
    if (w) begin
      push(K_ACK, c + 2, 32'h0, 4'h0, 32'h0, 1'b0);
      hold = 2;
    end else begin
      push(K_ACK, c + 2 + RL, 32'h0, 4'h0, exp_rd, 1'b1);
      hold = 2 + RL;
    end
    repeat (hold + 1) @(posedge clk);
    #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; dat_i = 32'h0;
  endtask

  initial begin
    int c, n0;
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, n0;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (!outs_zero()) begin
      errors++;
      $display("FAIL reset_outputs: got ack=%b gnt=%b en=%b addr=%h, required all zero", ack, acc_gnt, ram_en, ram_addr);
    end
    rst = 1'b0;

    // Contest 1 right after reset: WB wins, acc follows RD_LAT+3 cycles later
    @(posedge clk); #1;
    c = cyc_n;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h3800_0010;
    acc_req = 1'b1; acc_we = 1'b0; acc_addr = 10'd5; acc_wdata = 32'h0;
    push(K_EN,  c + 1,        32'd4, 4'h0, 32'h0, 1'b0);
    push(K_ACK, c + 2 + RL,   32'h0, 4'h0, 32'hA5A5_0004, 1'b1);
    push(K_EN,  c + 4 + RL,   32'd5, 4'h0, 32'h0, 1'b0);
    push(K_GNT, c + 4 + RL,   32'h0, 4'h0, 32'h0, 1'b0);
    push(K_RV,  c + 5 + 2*RL, 32'h0, 4'h0, 32'hA5A5_0005, 1'b1);
    repeat (RL + 3) @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    repeat (2) @(posedge clk); #1;
    acc_req = 1'b0;
    repeat (RL + 2) @(posedge clk);

    // Lone WB read of word 4
    wb_txn(32'h3800_0010, 1'b0, 4'hF, 32'h0, 4, 32'hA5A5_0004);
    // WB write with partial byte enables, then read the merged word back
    wb_txn(32'h3800_0008, 1'b1, 4'b0011, 32'hDEAD_BEEF, 2, 32'h0);
    wb_txn(32'h3800_0008, 1'b0, 4'hF, 32'h0, 2, 32'hA5A5_BEEF);

    // Contest 2: WB owned the last access, so the accelerator wins under round-robin
    @(posedge clk); #1;
    c = cyc_n;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h3800_001C;
    acc_req = 1'b1; acc_we = 1'b0; acc_addr = 10'd6; acc_wdata = 32'h0;
`ifdef MPRJRAM_ARB_WB_PRIO_EN
    push(K_EN,  c + 1,        32'd7, 4'h0, 32'h0, 1'b0);
    push(K_ACK, c + 2 + RL,   32'h0, 4'h0, 32'hA5A5_0007, 1'b1);
    push(K_EN,  c + 4 + RL,   32'd6, 4'h0, 32'h0, 1'b0);
    push(K_GNT, c + 4 + RL,   32'h0, 4'h0, 32'h0, 1'b0);
    push(K_RV,  c + 5 + 2*RL, 32'h0, 4'h0, 32'hA5A5_0006, 1'b1);
    repeat (RL + 3) @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    repeat (2) @(posedge clk); #1;
    acc_req = 1'b0;
    repeat (RL + 1) @(posedge clk); #1;
`else
    push(K_EN,  c + 1,        32'd6, 4'h0, 32'h0, 1'b0);
    push(K_GNT, c + 1,        32'h0, 4'h0, 32'h0, 1'b0);
    push(K_RV,  c + 2 + RL,   32'h0, 4'h0, 32'hA5A5_0006, 1'b1);
    push(K_EN,  c + 4 + RL,   32'd7, 4'h0, 32'h0, 1'b0);
    push(K_ACK, c + 5 + 2*RL, 32'h0, 4'h0, 32'hA5A5_0007, 1'b1);
    repeat (2) @(posedge clk); #1;
    acc_req = 1'b0;
    repeat (2*RL + 4) @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
`endif

    // acc_req held for three back-to-back writes to words 0..2
    @(posedge clk); #1;
    c = cyc_n;
    acc_req = 1'b1; acc_we = 1'b1; acc_addr = 10'd0; acc_wdata = 32'hC0DE_0000;
    for (int i = 0; i < 3; i++) begin
      push(K_EN,  c + 1 + 3*i, 32'(i), 4'hF, 32'hC0DE_0000 | 32'(i), 1'b0);
      push(K_GNT, c + 1 + 3*i, 32'h0, 4'h0, 32'h0, 1'b0);
    end
    repeat (2) @(posedge clk); #1;
    acc_addr = 10'd1; acc_wdata = 32'hC0DE_0001;
    repeat (3) @(posedge clk); #1;
    acc_addr = 10'd2; acc_wdata = 32'hC0DE_0002;
    repeat (3) @(posedge clk); #1;
    acc_req = 1'b0; acc_we = 1'b0; acc_addr = '0; acc_wdata = 32'h0;
    wb_txn(32'h3800_0004, 1'b0, 4'hF, 32'h0, 1, 32'hC0DE_0001);

    // WB abort: cycle dropped during WAIT, RAM read still issued, no ack
    @(posedge clk); #1;
    c = cyc_n;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h3800_0020;
    push(K_EN, c + 1, 32'd8, 4'h0, 32'h0, 1'b0);
    repeat (3) @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    repeat (RL + 2) @(posedge clk);

    // Reset pulse during WAIT of a WB read
    @(posedge clk); #1;
    c = cyc_n;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h3800_000C;
    push(K_EN, c + 1, 32'd3, 4'h0, 32'h0, 1'b0);
    repeat (5) @(posedge clk); #1;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0;
    #1;
    checks++;
    if (!outs_zero()) begin
      errors++;
      $display("FAIL midop_reset: got ack=%b en=%b addr=%h dat_o=%h rdata=%h, required all zero",
               ack, ram_en, ram_addr, dat_o, acc_rdata);
    end
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    wb_txn(32'h3800_000C, 1'b0, 4'hF, 32'h0, 3, 32'hA5A5_0003);

    // Address outside mprjram: never served
    @(posedge clk); #1;
    n0 = en_seen + ack_seen;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h3000_0000;
    repeat (50) @(posedge clk); #1;
    checks++;
    if (en_seen + ack_seen != n0) begin
      errors++;
      $display("FAIL out_of_range: got %0d ram_en/ack pulses, required 0", en_seen + ack_seen - n0);
    end
    cyc = 1'b0; stb = 1'b0;

    // Every queued expectation must have been seen
    repeat (5) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d expected pulses never seen (first kind %0d cycle %0d), required 0",
               exp_q.size(), exp_q[0].kind, exp_q[0].cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
